// File: rtl/icache_arb_pkg.sv
// Shared types and constants for the IF-stage line-fill read arbiter.
// The optional round-robin arbitration is selected with ICACHE_ARB_ROUND_ROBIN_EN.
package icache_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    AR   = 2'd1,
    R    = 2'd2,
    DONE = 2'd3
  } state_t;

  localparam logic [3:0] AXI_LEN_LINE   = 4'd7;
  localparam logic [2:0] AXI_SIZE_WORD  = 3'd2;
  localparam logic [1:0] AXI_BURST_INCR = 2'b01;

  localparam logic [3:0] DEF_ID0 = 4'd0;
  localparam logic [3:0] DEF_ID1 = 4'd1;

  localparam int LINE_WORDS_DEF   = 8;
  localparam int LINE_OFFSET_BITS = 5;

  // Align a byte address down to the start of its 32-byte line.
  function automatic logic [31:0] line_of(input logic [31:0] a);
    return {a[31:LINE_OFFSET_BITS], {LINE_OFFSET_BITS{1'b0}}};
  endfunction

endpackage

// File: rtl/icache_line_collector.sv
// Collects the beats of one line-fill burst into an 8x32 register file.
// The beat counter restarts on every burst start; the stored words are kept
// until overwritten, so a short burst leaves stale words in the upper slots.
module icache_line_collector #(
  parameter int LINE_WORDS = icache_arb_pkg::LINE_WORDS_DEF
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     clear,
  input  logic                     wr_en,
  input  logic [31:0]              wdata,
  output logic [LINE_WORDS*32-1:0] line
);

  localparam int CW = $clog2(LINE_WORDS);

  logic [CW-1:0] cnt;
  logic [31:0]   words [LINE_WORDS];

  // Beat counter and word storage; the counter wraps so a ninth beat lands in word 0.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
      for (int i = 0; i < LINE_WORDS; i++) words[i] <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else if (wr_en) begin
      words[cnt] <= wdata;
      cnt        <= cnt + 1'b1;
    end
  end

  // Flatten the register file, word i at bits [32i+31:32i].
  always_comb begin
    line = '0;
    for (int i = 0; i < LINE_WORDS; i++) line[32*i +: 32] = words[i];
  end

endmodule

// File: rtl/icache_rd_arbiter.sv
// Shares one AXI read-only master between the icache refill (requester 0) and
// the prefetch buffer (requester 1). Each grant runs one 8-beat INCR burst and
// hands the collected line back with a one-cycle gnt pulse.
// Handshake: an AXI transfer happens on a rising clk edge where valid and ready
// are both high; arvalid is held with stable fields until arready.
// Optional: define ICACHE_ARB_ROUND_ROBIN_EN to alternate winners when both
// requesters are pending; otherwise requester 0 always has priority.
module icache_rd_arbiter
  import icache_arb_pkg::*;
#(
  parameter int         LINE_WORDS = 8,
  parameter logic [3:0] ID0        = DEF_ID0,
  parameter logic [3:0] ID1        = DEF_ID1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     req0,
  input  logic [31:0]              addr0,
  output logic                     gnt0,
  input  logic                     req1,
  input  logic [31:0]              addr1,
  output logic                     gnt1,
  output logic [31:0]              line_addr,
  output logic [LINE_WORDS*32-1:0] line_data,
  output logic                     busy,
  output logic [3:0]               arid,
  output logic [31:0]              araddr,
  output logic [3:0]               arlen,
  output logic [2:0]               arsize,
  output logic [1:0]               arburst,
  output logic [1:0]               arlock,
  output logic [3:0]               arcache,
  output logic [2:0]               arprot,
  output logic                     arvalid,
  input  logic                     arready,
  input  logic [3:0]               rid,
  input  logic [31:0]              rdata,
  input  logic [1:0]               rresp,
  input  logic                     rlast,
  input  logic                     rvalid,
  output logic                     rready
);

  state_t state;
  logic   owner;
  logic   win;

  // Single outstanding burst, so the response id and status carry no information.
  logic   unused_r;
  assign unused_r = ^{rid, rresp};

`ifdef ICACHE_ARB_ROUND_ROBIN_EN
  logic last_owner;
`endif

  assign arlen   = AXI_LEN_LINE;
  assign arsize  = AXI_SIZE_WORD;
  assign arburst = AXI_BURST_INCR;
  assign arlock  = 2'b00;
  assign arcache = 4'b0000;
  assign arprot  = 3'b000;
  assign busy    = (state != IDLE);

  // Winner selection, only consulted in IDLE when some request is pending.
  always_comb begin
`ifdef ICACHE_ARB_ROUND_ROBIN_EN
    if (req0 && req1) win = ~last_owner;
    else              win = ~req0;
`else
    win = ~req0;
`endif
  end

  // Burst sequencer IDLE -> AR -> R -> DONE; all AXI and grant outputs registered.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      owner     <= 1'b0;
      gnt0      <= 1'b0;
      gnt1      <= 1'b0;
      arvalid   <= 1'b0;
      rready    <= 1'b0;
      araddr    <= '0;
      arid      <= '0;
      line_addr <= '0;
`ifdef ICACHE_ARB_ROUND_ROBIN_EN
      last_owner <= 1'b1;
`endif
    end else begin
      gnt0 <= 1'b0;
      gnt1 <= 1'b0;
      case (state)
        IDLE: begin
          if (req0 || req1) begin
            owner   <= win;
            araddr  <= line_of(win ? addr1 : addr0);
            arid    <= win ? ID1 : ID0;
            arvalid <= 1'b1;
            state   <= AR;
          end
        end
        AR: begin
          if (arready) begin
            arvalid <= 1'b0;
            rready  <= 1'b1;
            state   <= R;
          end
        end
        R: begin
          if (rvalid && rlast) begin
            rready    <= 1'b0;
            line_addr <= araddr;
            // The owner is granted only if still requesting; the other side
            // rides along when it wants the very same line.
            gnt0      <= req0 && (!owner || line_of(addr0) == araddr);
            gnt1      <= req1 && ( owner || line_of(addr1) == araddr);
`ifdef ICACHE_ARB_ROUND_ROBIN_EN
            last_owner <= owner;
`endif
            state     <= DONE;
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  icache_line_collector #(.LINE_WORDS(LINE_WORDS)) u_collector (
    .clk   (clk),
    .rst   (rst),
    .clear (arvalid && arready),
    .wr_en (rvalid && rready),
    .wdata (rdata),
    .line  (line_data)
  );

endmodule

// File: tb/tb_icache_rd_arbiter.sv
// Directed bench for icache_rd_arbiter with a small AXI read slave task.
module tb_icache_rd_arbiter;

  logic         clk = 1'b0;
  logic         rst;
  logic         req0, req1, gnt0, gnt1;
  logic [31:0]  addr0, addr1, line_addr, araddr, rdata;
  logic [255:0] line_data;
  logic         busy, arvalid, arready, rlast, rvalid, rready;
  logic [3:0]   arid, arlen, arcache, rid;
  logic [2:0]   arsize, arprot;
  logic [1:0]   arburst, arlock, rresp;

  int tests  = 0;
  int errors = 0;
  int cyc    = 0;

  always #5 clk = ~clk;

  icache_rd_arbiter dut (
    .clk(clk), .rst(rst),
    .req0(req0), .addr0(addr0), .gnt0(gnt0),
    .req1(req1), .addr1(addr1), .gnt1(gnt1),
    .line_addr(line_addr), .line_data(line_data), .busy(busy),
    .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize),
    .arburst(arburst), .arlock(arlock), .arcache(arcache), .arprot(arprot),
    .arvalid(arvalid), .arready(arready),
    .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid),
    .rready(rready)
  );

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic do_reset();
    rst = 1'b1; req0 = 1'b0; req1 = 1'b0; addr0 = '0; addr1 = '0;
    arready = 1'b0; rvalid = 1'b0; rlast = 1'b0; rdata = '0; rid = '0; rresp = '0;
    tick(); tick();
    rst = 1'b0;
  endtask

  // AXI slave: waits (bounded) for AR, accepts after ar_delay cycles, then
  // returns nbeats words base+i with gap idle cycles before each beat.
  // req1 is dropped right after beat index drop_at.
  task automatic serve(input int ar_delay, input int gap, input int nbeats,
                       input logic [31:0] base, input int drop_at,
                       output logic [31:0] got_addr, output logic [3:0] got_id,
                       output bit ok, output bit stable, output bit early);
    int n;
    ok = 1'b1; stable = 1'b1; early = 1'b0; got_addr = '0; got_id = '0; n = 0;
    while (arvalid !== 1'b1 && n < 50) begin tick(); n++; end
    if (arvalid !== 1'b1) begin ok = 1'b0; return; end
    got_addr = araddr; got_id = arid;
    repeat (ar_delay) begin
      tick();
      if (arvalid !== 1'b1 || araddr !== got_addr || arid !== got_id) stable = 1'b0;
      if (gnt0 === 1'b1 || gnt1 === 1'b1) early = 1'b1;
    end
    arready = 1'b1; tick(); arready = 1'b0;
    for (int i = 0; i < nbeats; i++) begin
      rvalid = 1'b0; rlast = 1'b0;
      repeat (gap) begin
        tick();
        if (gnt0 === 1'b1 || gnt1 === 1'b1) early = 1'b1;
      end
      if (rready !== 1'b1) ok = 1'b0;
      rvalid = 1'b1; rdata = base + i; rid = got_id; rlast = (i == nbeats - 1);
      tick();
      if (i != nbeats - 1 && (gnt0 === 1'b1 || gnt1 === 1'b1)) early = 1'b1;
      if (i == drop_at) req1 = 1'b0;
    end
    rvalid = 1'b0; rlast = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    tests++;
    if ({gnt0, gnt1, arvalid, rready, busy} !== 5'b0) begin
      errors++;
      $display("FAIL reset_ctrl: got %b exp 00000", {gnt0, gnt1, arvalid, rready, busy});
    end
    tests++;
    if (line_data !== 256'h0 || line_addr !== 32'h0 || araddr !== 32'h0 || arid !== 4'h0) begin
      errors++;
      $display("FAIL reset_data: line_addr %h araddr %h arid %h exp all zero", line_addr, araddr, arid);
    end
    tests++;
    if ({arlen, arsize, arburst, arlock, arcache, arprot} !== {4'd7, 3'd2, 2'b01, 2'b00, 4'd0, 3'd0}) begin
      errors++;
      $display("FAIL static_ar: got %h %h %h %h %h %h exp 7 2 1 0 0 0",
               arlen, arsize, arburst, arlock, arcache, arprot);
    end
  endtask

  task automatic test_basic();
    logic [31:0] a; logic [3:0] id; bit ok, st, early; int start;
    logic [255:0] exp_line;
    for (int i = 0; i < 8; i++) exp_line[32*i +: 32] = 32'h100 + i;
    do_reset();
    req0 = 1'b1; addr0 = 32'h1FC0_0014;
    tests++;
    if (arvalid !== 1'b0) begin errors++; $display("FAIL basic_no_ar_same_cycle: got %b exp 0", arvalid); end
    start = cyc;
    serve(0, 0, 8, 32'h100, -1, a, id, ok, st, early);
    tests++;
    if (!ok || a !== 32'h1FC0_0000 || id !== 4'd0) begin
      errors++; $display("FAIL basic_ar: ok %0d araddr %h arid %h exp 1 1fc00000 0", ok, a, id);
    end
    // request in cycle 0, gnt visible in cycle 10: the 11th cycle
    tests++;
    if (cyc - start != 10 || gnt0 !== 1'b1 || gnt1 !== 1'b0) begin
      errors++; $display("FAIL basic_gnt: edges %0d gnt0 %b gnt1 %b exp 10 1 0", cyc - start, gnt0, gnt1);
    end
    tests++;
    if (line_data !== exp_line || line_addr !== 32'h1FC0_0000) begin
      errors++; $display("FAIL basic_line: got %h @%h exp %h @1fc00000", line_data, line_addr, exp_line);
    end
    req0 = 1'b0;
    tick();
    tests++;
    if (gnt0 !== 1'b0 || busy !== 1'b0 || line_data !== exp_line) begin
      errors++; $display("FAIL basic_pulse: gnt0 %b busy %b exp 0 0, line held", gnt0, busy);
    end
  endtask

  task automatic test_priority();
    logic [31:0] a; logic [3:0] id; bit ok, st, early;
    do_reset();
    req0 = 1'b1; addr0 = 32'h1000; req1 = 1'b1; addr1 = 32'h2000;
    serve(0, 0, 8, 32'h200, -1, a, id, ok, st, early);
    tests++;
    if (!ok || a !== 32'h1000 || id !== 4'd0 || gnt0 !== 1'b1 || gnt1 !== 1'b0) begin
      errors++; $display("FAIL prio_first: ok %0d araddr %h arid %h gnt %b%b exp 1 1000 0 gnt 01", ok, a, id, gnt1, gnt0);
    end
    req0 = 1'b0;
    serve(0, 0, 8, 32'h300, -1, a, id, ok, st, early);
    tests++;
    if (!ok || a !== 32'h2000 || id !== 4'd1 || gnt0 !== 1'b0 || gnt1 !== 1'b1) begin
      errors++; $display("FAIL prio_second: ok %0d araddr %h arid %h gnt %b%b exp 1 2000 1 gnt 10", ok, a, id, gnt1, gnt0);
    end
    req1 = 1'b0;
    tick();
  endtask

  task automatic test_merge();
    logic [31:0] a; logic [3:0] id; bit ok, st, early, extra_ar;
    do_reset();
    req0 = 1'b1; addr0 = 32'h3004; req1 = 1'b1; addr1 = 32'h3018;
    serve(0, 0, 8, 32'h400, -1, a, id, ok, st, early);
    tests++;
    if (!ok || a !== 32'h3000 || gnt0 !== 1'b1 || gnt1 !== 1'b1 || line_addr !== 32'h3000) begin
      errors++; $display("FAIL merge_gnt: ok %0d araddr %h gnt %b%b line_addr %h exp 1 3000 11 3000", ok, a, gnt1, gnt0, line_addr);
    end
    req0 = 1'b0; req1 = 1'b0;
    extra_ar = 1'b0;
    repeat (6) begin tick(); if (arvalid !== 1'b0 || busy !== 1'b0) extra_ar = 1'b1; end
    tests++;
    if (extra_ar) begin errors++; $display("FAIL merge_single_ar: got extra burst exp 0"); end
  endtask

  task automatic test_stall();
    logic [31:0] a; logic [3:0] id; bit ok, st, early;
    logic [255:0] exp_line;
    for (int i = 0; i < 8; i++) exp_line[32*i +: 32] = 32'hA000 + i;
    do_reset();
    req0 = 1'b1; addr0 = 32'h4040;
    serve(5, 2, 8, 32'hA000, -1, a, id, ok, st, early);
    tests++;
    if (!ok || !st || a !== 32'h4040) begin
      errors++; $display("FAIL stall_ar_stable: ok %0d stable %0d araddr %h exp 1 1 4040", ok, st, a);
    end
    tests++;
    if (early || gnt0 !== 1'b1 || line_data !== exp_line) begin
      errors++; $display("FAIL stall_line: early %0d gnt0 %b data %h exp 0 1 %h", early, gnt0, line_data, exp_line);
    end
    req0 = 1'b0;
    tick();
  endtask

  task automatic test_drop();
    logic [31:0] a; logic [3:0] id; bit ok, st, early;
    do_reset();
    req1 = 1'b1; addr1 = 32'h5000;
    serve(0, 0, 8, 32'h500, 2, a, id, ok, st, early);
    tests++;
    if (!ok || a !== 32'h5000 || id !== 4'd1) begin
      errors++; $display("FAIL drop_burst: ok %0d araddr %h arid %h exp 1 5000 1", ok, a, id);
    end
    tests++;
    if (gnt0 !== 1'b0 || gnt1 !== 1'b0 || line_addr !== 32'h5000 || busy !== 1'b1) begin
      errors++; $display("FAIL drop_no_gnt: gnt %b%b line_addr %h busy %b exp 00 5000 1", gnt1, gnt0, line_addr, busy);
    end
    tick();
    req0 = 1'b1; addr0 = 32'h6000;
    serve(0, 0, 8, 32'h600, -1, a, id, ok, st, early);
    tests++;
    if (!ok || a !== 32'h6000 || gnt0 !== 1'b1 || gnt1 !== 1'b0) begin
      errors++; $display("FAIL drop_next: ok %0d araddr %h gnt %b%b exp 1 6000 01", ok, a, gnt1, gnt0);
    end
    req0 = 1'b0;
    tick();
  endtask

  task automatic test_rr();
    logic [31:0] a; logic [3:0] id; bit ok, st, early;
    logic exp_id;
    do_reset();
    req0 = 1'b1; addr0 = 32'h7000; req1 = 1'b1; addr1 = 32'h8000;
    for (int k = 0; k < 4; k++) begin
`ifdef ICACHE_ARB_ROUND_ROBIN_EN
      exp_id = k[0];
`else
      exp_id = 1'b0;
`endif
      serve(0, 0, 8, 32'h700 + 32'h10 * k, -1, a, id, ok, st, early);
      tests++;
      if (!ok || id !== {3'b0, exp_id} || a !== (exp_id ? 32'h8000 : 32'h7000)
          || gnt0 !== ~exp_id || gnt1 !== exp_id) begin
        errors++;
        $display("FAIL rr_burst%0d: ok %0d arid %h araddr %h gnt %b%b exp winner %0d", k, ok, id, a, gnt1, gnt0, exp_id);
      end
    end
    req0 = 1'b0; req1 = 1'b0;
    tick();
  endtask

  task automatic test_reset_mid();
    do_reset();
    req0 = 1'b1; addr0 = 32'h9000;
    tick();
    arready = 1'b1; tick(); arready = 1'b0;
    rvalid = 1'b1; rdata = 32'hDEAD_0000; tick();
    rdata = 32'hDEAD_0001; tick();
    rvalid = 1'b0; req0 = 1'b0;
    tests++;
    if (busy !== 1'b1 || rready !== 1'b1) begin
      errors++; $display("FAIL rstmid_in_r: busy %b rready %b exp 1 1", busy, rready);
    end
    rst = 1'b1;
    tick();
    tests++;
    if (busy !== 1'b0 || arvalid !== 1'b0 || rready !== 1'b0 || gnt0 !== 1'b0 || line_data !== 256'h0) begin
      errors++; $display("FAIL rstmid_idle: busy %b arvalid %b rready %b gnt0 %b exp 0 0 0 0", busy, arvalid, rready, gnt0);
    end
    rst = 1'b0;
    tick();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_priority();
    test_merge();
    test_stall();
    test_drop();
    test_rr();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, errors);
    $finish;
  end

endmodule

// File: doc/icache_rd_arbiter.md
Name: icache_rd_arbiter

Overview:
- Shares one AXI read-only master port between two line-fill requesters.
- Requester 0 is the icache miss refill; requester 1 is the instruction prefetch buffer.
- Each grant issues one 8-beat INCR burst (32-byte line), collects the beats into a line buffer, then hands the line to the winner with a one-cycle grant pulse.
- Sits in IF, between the icache/prefetch pair and the instr AXI bus.

Parameters:
- LINE_WORDS, 8, beats per burst / words per line (fixed; arlen = LINE_WORDS-1).
- ID0, 4'd0, arid used for requester 0.
- ID1, 4'd1, arid used for requester 1.

Ports:
- clk in 1: clock.
- rst in 1: reset.
- req0 in 1: requester 0 line request, held until gnt0.
- addr0 in 32: requester 0 physical address.
- gnt0 out 1: one-cycle pulse, line_data valid for requester 0.
- req1 in 1: requester 1 line request.
- addr1 in 32: requester 1 physical address.
- gnt1 out 1: one-cycle pulse for requester 1.
- line_addr out 32: line-aligned address of line_data.
- line_data out 256: word i at bits [32i+31:32i].
- busy out 1: high in any state other than IDLE.
- arid out 4, araddr out 32, arlen out 4, arsize out 3, arburst out 2, arlock out 2, arcache out 4, arprot out 3, arvalid out 1: AXI AR channel.
- arready in 1: AXI AR channel.
- rid in 4, rdata in 32, rresp in 2, rlast in 1, rvalid in 1: AXI R channel.
- rready out 1: AXI R channel.

Behaviour:
- Interface: one clock, clk; synchronous active-high reset, rst.
- Reset: state = IDLE; gnt0, gnt1, arvalid, rready, busy = 0; line_data, line_addr, araddr, arid = 0; beat counter = 0.
- Static AR fields: arlen = 4'd7, arsize = 3'd2, arburst = 2'b01, arlock = 0, arcache = 0, arprot = 0.
- Line address: {addr[31:5], 5'b0}.

State machine IDLE -> AR -> R -> DONE -> IDLE:
- IDLE:
  - If any req is high, pick a winner: fixed priority, req0 over req1.
  - Latch owner, araddr = the winner's line address, arid = the winner's ID.
  - Next state AR. No AR is issued in the same cycle as the request (1-cycle arbitration latency).
- AR:
  - arvalid = 1, held with stable fields until arready.
  - On arvalid && arready, go to R and clear the beat counter.
- R:
  - rready = 1.
  - On each rvalid, line_data[cnt] <= rdata and cnt increments (3 bits, wraps).
  - Transfer with rlast -> DONE.
  - rresp and rid are ignored (single outstanding transaction).
  - If rlast arrives before 8 beats, unwritten words keep stale data.
  - If 8 beats arrive without rlast, stay in R; the 9th beat overwrites word 0.
- DONE:
  - line_addr = araddr.
  - gnt[owner] = req[owner].
  - The other requester is also granted if its req is high and its line address equals araddr (merge).
  - Next state IDLE. A new arbitration can win on the following cycle.

Boundary cases:
- Requester drops req mid-burst: the burst still completes (AXI cannot abort), and no gnt is given to it.
- Minimum request-to-gnt latency: 1 (IDLE) + 1 (AR, arready immediate) + 8 (beats) + 1 (DONE) = 11 cycles.
- rst asserted mid-burst: return to IDLE at once. The external AXI slave is reset by the same rst.
- gnt pulses never occur in any state other than DONE.
- line_data is held until the next burst's first beat.

Optional Feature:
- Macro: ICACHE_ARB_ROUND_ROBIN_EN.
- Defined:
  - Add a 1-bit last_owner register, reset to 1.
  - In IDLE with both reqs high, the winner is ~last_owner.
  - last_owner is updated on entry to DONE.
- Undefined: fixed priority req0 > req1. This prevents starvation of prefetch behind back-to-back misses only when the macro is defined.

Decomposition:
- Package icache_arb_pkg:
  - state enum {IDLE, AR, R, DONE};
  - localparams AXI_LEN_LINE = 4'd7, AXI_SIZE_WORD = 3'd2, AXI_BURST_INCR = 2'b01;
  - ID0/ID1 defaults; LINE_OFFSET_BITS = 5.
- One natural sub-module, icache_line_collector: beat counter plus 8x32 register file written on rvalid&&rready, clear on burst start, outputs the flattened 256-bit line.

Test Plan:
- req0 = 1, addr0 = 0x1FC0_0014; arready immediate; rdata = 0x100+i per beat -> araddr = 0x1FC0_0000, arid = 0, line_data word i = 0x100+i, gnt0 pulses at cycle 11, gnt1 = 0.
- req0 and req1 both high (addr0 = 0x1000, addr1 = 0x2000), fixed priority -> first burst araddr = 0x1000/gnt0, second araddr = 0x2000/gnt1.
- req0 = 0x3004, req1 = 0x3018 (same line) -> exactly one AR burst at 0x3000; gnt0 and gnt1 pulse in the same cycle.
- arready delayed 5 cycles, rvalid with 2-cycle gaps -> arvalid and araddr stable throughout; all 8 words are correct; gnt comes after rlast only.
- req1 dropped at beat 3 of its burst -> burst completes, rready stays high to rlast, gnt1 stays 0, next req0 is served.
- ICACHE_ARB_ROUND_ROBIN_EN defined, req0 and req1 held high continuously -> winners alternate 0, 1, 0, 1 over 4 bursts. Reset mid-R -> busy = 0 and arvalid = 0 on the next cycle.
